// File: rtl/fft_modulus_frame_ctrl.sv
// Captures one FFT modulus frame into the companion FIFO and drains it to a valid/ready consumer.
// Optional drop counter / error flag are built when FFT_MOD_FRAME_STAT_EN is defined.
module fft_modulus_frame_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DEPTH_W   = 10,
    parameter int FRAME_LEN = 1024,
    parameter int CONT_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] mod_data,
    input  logic              mod_valid,
    input  logic              mod_sop,
    output logic              fifo_rst,
    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wr_data,
    input  logic              fifo_full,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rd_data,
    input  logic              fifo_empty,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              frame_done
`ifdef FFT_MOD_FRAME_STAT_EN
    ,
    output logic [15:0]       drop_cnt,
    output logic              err_flag
`endif
);

    localparam int CW = DEPTH_W + 1;
    localparam logic [CW-1:0] LEN    = CW'(FRAME_LEN);
    localparam logic [CW-1:0] LEN_M1 = CW'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_CAPTURE, S_FLUSH, S_READ, S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     wr_cnt, rd_cnt, out_cnt;
    logic [DATA_W-1:0] buf0, buf1;
    logic [1:0]        occ;
    logic              infl;
    logic              pop, last_xfer;
    logic [2:0]        room;
    logic [1:0]        wpos;

    // Valid/ready: a word moves when out_valid && out_ready on a rising edge; while out_valid is
    // high and out_ready low, out_data/out_last hold and out_valid stays high.
    assign out_valid    = (occ != 2'd0);
    assign out_data     = buf0;
    assign out_last     = out_valid && (out_cnt == LEN_M1);
    assign pop          = out_valid && out_ready;
    assign last_xfer    = pop && (out_cnt == LEN_M1);
    assign busy         = (state != S_IDLE);
    assign fifo_rst     = !rst_n || (state == S_FLUSH);
    assign fifo_wr_data = fifo_wr_en ? mod_data : '0;
    assign room         = {1'b0, occ} + {2'b0, infl} - {2'b0, pop};
    assign wpos         = occ - {1'b0, pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (CONT_MODE != 0 || start) state_nxt = S_ARM;
            S_ARM:     if (mod_valid && mod_sop)
                           state_nxt = (FRAME_LEN == 1) ? S_READ : S_CAPTURE;
            S_CAPTURE: if (mod_valid) begin
                           if (mod_sop || fifo_full)  state_nxt = S_FLUSH;
                           else if (wr_cnt == LEN_M1) state_nxt = S_READ;
                       end
            S_FLUSH:   state_nxt = S_ARM;
            S_READ:    if (last_xfer) state_nxt = S_DONE;
            S_DONE:    state_nxt = (CONT_MODE != 0) ? S_ARM : S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_wr_en = 1'b0;
        fifo_rd_en = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_ARM:     fifo_wr_en = mod_valid && mod_sop;
            S_CAPTURE: fifo_wr_en = mod_valid && !mod_sop && !fifo_full;
            // Never let held plus in-flight words exceed the two skid entries.
            S_READ:    fifo_rd_en = (rd_cnt < LEN) && !fifo_empty && (room < 3'd2);
            S_DONE:    frame_done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            out_cnt <= '0;
            occ     <= 2'd0;
            infl    <= 1'b0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            if (state == S_IDLE || state == S_FLUSH || state == S_DONE) begin
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                out_cnt <= '0;
            end else begin
                if (fifo_wr_en) wr_cnt  <= wr_cnt + CW'(1);
                if (fifo_rd_en) rd_cnt  <= rd_cnt + CW'(1);
                if (pop)        out_cnt <= out_cnt + CW'(1);
            end
            infl <= fifo_rd_en;
            occ  <= occ + {1'b0, infl} - {1'b0, pop};
            // Returning read data lands behind whatever survives this cycle's pop.
            if (pop) buf1 <= buf1;
            if (pop) buf0 <= buf1;
            if (infl) begin
                if (wpos == 2'd0) buf0 <= fifo_rd_data;
                else              buf1 <= fifo_rd_data;
            end
        end
    end

`ifdef FFT_MOD_FRAME_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
            err_flag <= 1'b0;
        end else begin
            if (busy && mod_valid && !fifo_wr_en && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (state != S_FLUSH && state_nxt == S_FLUSH) err_flag <= 1'b1;
            else if (start)                               err_flag <= 1'b0;
        end
    end
`endif

endmodule
